// File: rtl/soft_combine_pkg.sv
// rtl/soft_combine_pkg.sv - shared types, defaults and lane arithmetic for the soft combine engine
// Build option: SOFT_COMBINE_SAT_EN selects saturating lane sums instead of wrapping.
package soft_combine_pkg;

   localparam int DEF_LANES  = 16;
   localparam int DEF_LLR_W  = 6;
   localparam int DEF_ADDR_W = 12;
   localparam int DEF_USER_W = 4;

   // Lane sums are formed at this width; callers keep the low LLR_W bits.
   localparam int LANE_MAX = 32;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_FILL    = 4'b0010,
      ST_COMBINE = 4'b0100,
      ST_DRAIN   = 4'b1000
   } state_t;

   function automatic logic signed [LANE_MAX-1:0] lane_add(
      input logic signed [LANE_MAX-1:0] a,
      input logic signed [LANE_MAX-1:0] b,
      input int                         w
   );
      logic signed [LANE_MAX-1:0] s;
`ifdef SOFT_COMBINE_SAT_EN
      logic signed [LANE_MAX-1:0] hi;
      logic signed [LANE_MAX-1:0] lo;
`endif
      s = a + b;
`ifdef SOFT_COMBINE_SAT_EN
      hi = $signed((LANE_MAX'(1) << (w - 1)) - LANE_MAX'(1));
      lo = ~hi;
      if (s > hi) begin
         s = hi;
      end else if (s < lo) begin
         s = lo;
      end
`else
      s = (s <<< (LANE_MAX - w)) >>> (LANE_MAX - w);
`endif
      return s;
   endfunction

endpackage

// File: rtl/soft_combine_ram.sv
// rtl/soft_combine_ram.sv - simple dual-port buffer RAM, one clock, registered read
module soft_combine_ram #(
   parameter int W  = 96,
   parameter int AW = 12
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [0:(1<<AW)-1];
   logic [W-1:0] r_rdata;

   // Read returns the old contents on a same-cycle address collision.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/soft_combine_engine.sv
// rtl/soft_combine_engine.sv - receive-side fill/combine into a circular buffer, then drain
// Build option: SOFT_COMBINE_SAT_EN selects saturating lane sums instead of wrapping.
module soft_combine_engine
   import soft_combine_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int LLR_W  = DEF_LLR_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int USER_W = DEF_USER_W
) (
   input  logic                   i_core_clk,
   input  logic                   i_rx_rst,
   input  logic                   i_process_request,
   input  logic [USER_W-1:0]      i_process_user_idx,
   input  logic [ADDR_W:0]        i_ncb_words,
   output logic                   o_req_ack,
   input  logic                   i_data_valid,
   input  logic [LANES*LLR_W-1:0] i_data,
   input  logic                   i_data_last,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [LANES*LLR_W-1:0] o_out_data,
   output logic                   o_out_last,
   output logic [USER_W-1:0]      o_out_user,
   output logic                   o_busy
);

   localparam int DW = LANES * LLR_W;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [USER_W-1:0]   r_user;
   logic [ADDR_W:0]     r_ncb;
   logic [ADDR_W-1:0]   r_last_addr;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [ADDR_W:0]     r_fill_cnt;
   logic [ADDR_W:0]     r_rd_ptr;
   logic                r_last_pend;
   logic                r_req_ack;

   logic                r_s1_valid;
   logic                r_s1_comb;
   logic                r_s1_byp;
   logic [ADDR_W-1:0]   r_s1_addr;
   logic [DW-1:0]       r_s1_data;
   logic [DW-1:0]       r_byp_data;

   logic                r_d1_valid;
   logic                r_d1_zero;
   logic                r_d1_last;
   logic                r_out_valid;
   logic                r_out_last;
   logic [DW-1:0]       r_out_data;
   logic                r_skid_valid;
   logic                r_skid_last;
   logic [DW-1:0]       r_skid_data;

   logic                w_in_stream;
   logic                w_accept;
   logic                w_at_end;
   logic                w_hs;
   logic [1:0]          w_occ;
   logic                w_drain_issue;
   logic                w_rd_en;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [DW-1:0]       w_ram_dout;
   logic [DW-1:0]       w_old;
   logic [DW-1:0]       w_sum;
   logic [DW-1:0]       w_wr_data;
   logic [DW-1:0]       w_d1_word;

   assign w_in_stream = (r_state == ST_FILL) || (r_state == ST_COMBINE);
   assign w_accept    = i_data_valid && w_in_stream && !r_last_pend;
   assign w_at_end    = (r_wr_addr == r_last_addr);
   assign w_hs        = r_out_valid && i_out_ready;

   // Words in flight toward the output; a read is issued only if it can land in out or skid.
   assign w_occ         = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_d1_valid};
   assign w_drain_issue = (r_state == ST_DRAIN) && (r_rd_ptr < r_ncb) &&
                          (w_occ <= (2'd1 + {1'b0, w_hs}));

   assign w_rd_en   = w_drain_issue || (w_accept && (r_state == ST_COMBINE));
   assign w_rd_addr = (r_state == ST_DRAIN) ? r_rd_ptr[ADDR_W-1:0] : r_wr_addr;

   assign w_old     = r_s1_byp ? r_byp_data : w_ram_dout;
   assign w_wr_data = r_s1_comb ? w_sum : r_s1_data;
   assign w_d1_word = r_d1_zero ? '0 : w_ram_dout;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_sum[g*LLR_W +: LLR_W] = LLR_W'(lane_add(
         LANE_MAX'($signed(r_s1_data[g*LLR_W +: LLR_W])),
         LANE_MAX'($signed(w_old[g*LLR_W +: LLR_W])),
         LLR_W));
   end

   soft_combine_ram #(
      .W  (DW),
      .AW (ADDR_W)
   ) u_ram (
      .i_clk   (i_core_clk),
      .i_we    (r_s1_valid),
      .i_waddr (r_s1_addr),
      .i_wdata (w_wr_data),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_dout)
   );

   // The last word is written back in the cycle after it arrives, so DRAIN waits one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (i_process_request) w_state_nxt = ST_FILL;
         ST_FILL: begin
            if (r_last_pend) begin
               w_state_nxt = ST_DRAIN;
            end else if (w_accept && !i_data_last && w_at_end) begin
               w_state_nxt = ST_COMBINE;
            end
         end
         ST_COMBINE: if (r_last_pend) w_state_nxt = ST_DRAIN;
         ST_DRAIN:   if (w_hs && r_out_last) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         r_state     <= ST_IDLE;
         r_user      <= '0;
         r_ncb       <= '0;
         r_last_addr <= '0;
         r_wr_addr   <= '0;
         r_fill_cnt  <= '0;
         r_rd_ptr    <= '0;
         r_last_pend <= 1'b0;
         r_req_ack   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_req_ack <= (r_state == ST_IDLE) && i_process_request;
         if ((r_state == ST_IDLE) && i_process_request) begin
            r_user      <= i_process_user_idx;
            r_ncb       <= i_ncb_words;
            r_last_addr <= ADDR_W'(i_ncb_words - (ADDR_W+1)'(1));
            r_wr_addr   <= '0;
            r_fill_cnt  <= '0;
            r_rd_ptr    <= '0;
            r_last_pend <= 1'b0;
         end
         if (w_accept) begin
            r_wr_addr <= w_at_end ? '0 : r_wr_addr + ADDR_W'(1);
            if (r_state == ST_FILL) begin
               r_fill_cnt <= r_fill_cnt + (ADDR_W+1)'(1);
            end
            if (i_data_last) begin
               r_last_pend <= 1'b1;
            end
         end
         if (w_drain_issue) begin
            r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
         end
      end
   end

   // Stage 1 holds the accepted word for its write-back; bypass covers a read of the address being written.
   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_comb  <= 1'b0;
         r_s1_byp   <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_data  <= '0;
         r_byp_data <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_addr  <= r_wr_addr;
            r_s1_data  <= i_data;
            r_s1_comb  <= (r_state == ST_COMBINE);
            r_s1_byp   <= r_s1_valid && (r_s1_addr == r_wr_addr);
            r_byp_data <= w_wr_data;
         end
      end
   end

   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         r_d1_valid   <= 1'b0;
         r_d1_zero    <= 1'b0;
         r_d1_last    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_last  <= 1'b0;
         r_skid_data  <= '0;
      end else begin
         r_d1_valid <= w_drain_issue;
         if (w_drain_issue) begin
            r_d1_zero <= (r_rd_ptr >= r_fill_cnt);
            r_d1_last <= (r_rd_ptr == (r_ncb - (ADDR_W+1)'(1)));
         end
         if (!r_out_valid || w_hs) begin
            if (r_skid_valid) begin
               r_out_valid  <= 1'b1;
               r_out_data   <= r_skid_data;
               r_out_last   <= r_skid_last;
               r_skid_valid <= r_d1_valid;
               r_skid_data  <= w_d1_word;
               r_skid_last  <= r_d1_last;
            end else if (r_d1_valid) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_d1_word;
               r_out_last  <= r_d1_last;
            end else begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end
         end else if (r_d1_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_d1_word;
            r_skid_last  <= r_d1_last;
         end
      end
   end

   assign o_req_ack   = r_req_ack;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_out_user  = r_user;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: doc/soft_combine_engine.md
# soft_combine_engine

Parametrised successor of the receive-side fill/combine FSM. Accepts one user's stream of LANES-wide soft-bit (LLR) words and writes the first i_ncb_words words into an internal circular buffer. Each later (repeated) word is added lane-wise to the stored word at the same wrapped address. After the last input word it drains the combined buffer to the downstream rate-dematcher/decoder under valid/ready backpressure.

## Interface
- LANES, 16, soft bits per word
- LLR_W, 6, signed bits per soft bit
- ADDR_W, 12, buffer address width; depth 2**ADDR_W words
- USER_W, 4, user index width
- i_core_clk  in  1  core clock; all logic on rising edge
- i_rx_rst  in  1  synchronous, active-high reset
- i_process_request  in  1  start pulse; sampled only in IDLE
- i_process_user_idx  in  USER_W  user tag, latched with the request
- i_ncb_words  in  ADDR_W+1  circular-buffer length in words, 1..2**ADDR_W; latched with the request
- o_req_ack  out  1  one-cycle pulse when a request is accepted
- i_data_valid  in  1  input word strobe; no input backpressure
- i_data  in  LANES*LLR_W  input word; lane k = bits [k*LLR_W +: LLR_W]
- i_data_last  in  1  marks the final input word; qualified by i_data_valid
- o_out_valid  out  1  drain word valid
- i_out_ready  in  1  downstream ready
- o_out_data  out  LANES*LLR_W  combined word
- o_out_last  out  1  on drain word i_ncb_words-1
- o_out_user  out  USER_W  latched user tag
- o_busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, FILL, COMBINE, DRAIN (one-hot).
- IDLE: i_process_request=1 latches user and ncb_words, clears wr_addr and fill_cnt, pulses o_req_ack, then goes to FILL.
- FILL: each valid word is written unmodified at wr_addr.
  - wr_addr == ncb_words-1 with valid: wr_addr wraps to 0 and the state goes to COMBINE.
  - fill_cnt counts the words written.
- COMBINE: each valid word is read, added lane-wise to the stored word and written back at wr_addr; wr_addr wraps at ncb_words-1.
- i_data_last with valid, in FILL or COMBINE: that word is processed normally, then the state goes to DRAIN.
- Short input: if the last word arrives in FILL, addresses >= fill_cnt drain as all-zero words.
- DRAIN: outputs words 0..ncb_words-1 in order, then returns to IDLE.
- Ignored inputs:
  - i_process_request outside IDLE; no ack.
  - i_data_valid in IDLE and in DRAIN.
- Lane arithmetic: LLR_W+1-bit signed sum, reduced per Configuration.
- RAW hazard: read address equal to the write address of the previous cycle (ncb_words=1, or back-to-back wrap) takes the pending write data through a bypass, never the RAM output.
- Reset: state to IDLE, counters to 0. RAM contents are not cleared; fill_cnt=0 guarantees stale data never drains.

## Timing
- Reset values: o_req_ack, o_out_valid, o_out_last, o_busy = 0; o_out_data, o_out_user = 0.
- RAM read latency 1. A COMBINE word valid at cycle t is read at t and written back at t+1. Sustained throughput is 1 word/cycle.
- The state enters DRAIN at t+2 after the last word at t, so the final write-back is complete.
- First o_out_valid at 2 cycles after DRAIN entry.
- With i_out_ready held high, one word per cycle.
- o_out_data/o_out_last are stable while o_out_valid=1 and i_out_ready=0.
- Back-to-back: o_busy falls the cycle after the o_out_last handshake. A request in that cycle is accepted.

## Configuration
- SOFT_COMBINE_SAT_EN defined: each lane sum saturates to [-(2**(LLR_W-1)), 2**(LLR_W-1)-1].
- SOFT_COMBINE_SAT_EN undefined: each lane sum wraps (low LLR_W bits, two's complement).

## Structure
- soft_combine_pkg holds:
  - state encoding constants;
  - default LANES/LLR_W/ADDR_W/USER_W;
  - function lane_add(a, b) containing the SOFT_COMBINE_SAT_EN switch.
- Sub-module soft_combine_ram: simple dual-port, one clock, registered read, LANES*LLR_W x 2**ADDR_W.
- Bypass and the drain skid register stay in the top level.

## Test plan
- Fill only: ncb_words=4, 4 words, all lanes = 1,2,3,4, last on word 4 -> drain 4 words of 1,2,3,4; o_out_last on the 4th; o_out_user = request idx.
- Combine with wrap: ncb_words=3, 7 words, all lanes +5 -> drain lanes 15,10,10 (words 0, 1, 2).
- Saturation: ncb_words=1, 3 words of lane value +20, LLR_W=6.
  - Macro defined: output +31.
  - Undefined: 60 mod 64 = -4.
  - Both cases exercise the RAW bypass.
- Short input: ncb_words=8, 3 words then last -> words 3..7 drain as 0 even after a prior run left nonzero RAM.
- Backpressure: i_out_ready toggled 1,0,0,1 during DRAIN -> no word lost or duplicated; data held while stalled.
- Reset mid-COMBINE: assert i_rx_rst for 1 cycle -> next cycle o_busy=0, o_out_valid=0; a new request with ncb_words=2 is acked and behaves like fill-only.
